// File: rtl/fab_apb_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fab_apb_rr_arbiter
//
// Round-robin arbiter plus APB3 master sequencer. NUM_REQ fabric requesters
// share one APB3 slave port. Each requester presents a single read or write
// command on REQ_VALID and holds it until it sees its REQ_DONE pulse. Commands
// are serialised into APB3 SETUP/ACCESS phases. Read data and the error flag
// come back on RSP_RDATA/RSP_ERR alongside REQ_DONE. A PREADY watchdog aborts
// an ACCESS phase that never completes.
//
// Ports
//   PCLK, PRESETN           clock, asynchronous active-low reset
//   REQ_VALID/REQ_WRITE     per-requester command valid / write select
//   REQ_ADDR, REQ_WDATA     packed per-requester address / write data
//   REQ_DONE                one-cycle completion pulse to the granted requester
//   RSP_RDATA, RSP_ERR      response, valid only while REQ_DONE is high
//   BUSY                    high whenever the sequencer is not idle
//   PSEL..PWDATA            APB3 master outputs
//   PRDATA/PREADY/PSLVERR   APB3 slave responses
//
// All outputs are registered. Each output's next value is derived from the
// FSM's next state.
// -----------------------------------------------------------------------------
module fab_apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [NUM_REQ-1:0]    REQ_WRITE,
    input  logic [NUM_REQ*AW-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DW-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]    REQ_DONE,
    output logic [DW-1:0]         RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [AW-1:0]         PADDR,
    output logic [DW-1:0]         PWDATA,
    input  logic [DW-1:0]         PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // A disabled watchdog still needs a legal vector width.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [GW-1:0]  GNT_INIT = GW'(NUM_REQ - 1);
    // Abort point. With the watchdog disabled the counter just parks at all-ones.
    localparam logic [WDW-1:0] WD_LAST  = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : {WDW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [GW-1:0]    last_gnt_reg, last_gnt_next;
    logic [WDW-1:0]   wdog_reg, wdog_next;

    logic [NUM_REQ-1:0] done_next;
    logic [DW-1:0]      rdata_next;
    logic               err_next;
    logic               busy_next;
    logic               psel_next;
    logic               penable_next;
    logic               pwrite_next;
    logic [AW-1:0]      paddr_next;
    logic [DW-1:0]      pwdata_next;

    logic               arb_found;
    logic [GW-1:0]      arb_gnt;

    // Per-requester views of the packed command buses.
    logic [AW-1:0] req_addr_arr  [NUM_REQ];
    logic [DW-1:0] req_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = REQ_ADDR[gi*AW +: AW];
            assign req_wdata_arr[gi] = REQ_WDATA[gi*DW +: DW];
        end
    endgenerate

    // Round-robin search: start one above the last grant and wrap, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = last_gnt_reg;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && REQ_VALID[(int'(last_gnt_reg) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_gnt   = GW'((int'(last_gnt_reg) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        wdog_next     = wdog_reg;
        done_next     = '0;
        rdata_next    = '0;
        err_next      = 1'b0;
        psel_next     = 1'b0;
        penable_next  = 1'b0;
        pwrite_next   = PWRITE;
        paddr_next    = PADDR;
        pwdata_next   = PWDATA;

        case (state_reg)
            ST_IDLE: begin
                if (arb_found) begin
                    state_next    = ST_SETUP;
                    last_gnt_next = arb_gnt;
                    paddr_next    = req_addr_arr[arb_gnt];
                    pwdata_next   = req_wdata_arr[arb_gnt];
                    pwrite_next   = REQ_WRITE[arb_gnt];
                    psel_next     = 1'b1;
                end
            end

            ST_SETUP: begin
                state_next   = ST_ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end

            ST_ACCESS: begin
                psel_next    = 1'b1;
                penable_next = 1'b1;
                if (wdog_reg != WD_LAST) begin
                    wdog_next = wdog_reg + WDW'(1);
                end
                // PREADY is checked first so it wins over a coincident timeout.
                if (PREADY) begin
                    state_next              = ST_RESP;
                    psel_next               = 1'b0;
                    penable_next            = 1'b0;
                    done_next[last_gnt_reg] = 1'b1;
                    rdata_next              = PWRITE ? '0 : PRDATA;
                    err_next                = PSLVERR;
                end else if (TIMEOUT != 0 && wdog_reg == WD_LAST) begin
                    state_next              = ST_RESP;
                    psel_next               = 1'b0;
                    penable_next            = 1'b0;
                    done_next[last_gnt_reg] = 1'b1;
                    err_next                = 1'b1;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
                wdog_next  = '0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg    <= ST_IDLE;
            last_gnt_reg <= GNT_INIT;
            wdog_reg     <= '0;
            REQ_DONE     <= '0;
            RSP_RDATA    <= '0;
            RSP_ERR      <= 1'b0;
            BUSY         <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            wdog_reg     <= wdog_next;
            REQ_DONE     <= done_next;
            RSP_RDATA    <= rdata_next;
            RSP_ERR      <= err_next;
            BUSY         <= busy_next;
            PSEL         <= psel_next;
            PENABLE      <= penable_next;
            PWRITE       <= pwrite_next;
            PADDR        <= paddr_next;
            PWDATA       <= pwdata_next;
        end
    end

endmodule

// File: tb/tb_fab_apb_rr_arbiter.sv
`timescale 1ns/1ps
// Testbench for fab_apb_rr_arbiter. Two instances share all inputs: "dut"
// with an 8-cycle watchdog and "dut0" with the watchdog disabled. The bench
// plays the APB slave. Expected responses go into a queue when a command is
// driven and are popped when REQ_DONE pulses.
module tb_fab_apb_rr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 16;
    localparam int DW      = 32;

    logic                  PCLK = 1'b0;
    logic                  PRESETN;
    logic [NUM_REQ-1:0]    REQ_VALID, REQ_WRITE;
    logic [NUM_REQ*AW-1:0] REQ_ADDR;
    logic [NUM_REQ*DW-1:0] REQ_WDATA;
    logic [DW-1:0]         PRDATA;
    logic                  PREADY, PSLVERR;

    logic [NUM_REQ-1:0] REQ_DONE;
    logic [DW-1:0]      RSP_RDATA;
    logic               RSP_ERR, BUSY, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;

    logic [NUM_REQ-1:0] z_done;
    logic [DW-1:0]      z_rdata;
    logic               z_err, z_busy, z_psel, z_penable, z_pwrite;
    logic [AW-1:0]      z_paddr;
    logic [DW-1:0]      z_pwdata;

    // Slave model: fixed read data, or data derived from the address.
    logic          rdata_by_addr;
    logic [DW-1:0] prdata_val;
    assign PRDATA = rdata_by_addr ? {PADDR, ~PADDR} : prdata_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 PCLK = ~PCLK;

    fab_apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(REQ_DONE), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    fab_apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(0)) dut0 (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(z_done), .RSP_RDATA(z_rdata), .RSP_ERR(z_err), .BUSY(z_busy),
        .PSEL(z_psel), .PENABLE(z_penable), .PWRITE(z_pwrite), .PADDR(z_paddr), .PWDATA(z_pwdata),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic apply_reset();
        PRESETN       = 1'b0;
        REQ_VALID     = '0;
        REQ_WRITE     = '0;
        REQ_ADDR      = '0;
        REQ_WDATA     = '0;
        PREADY        = 1'b1;
        PSLVERR       = 1'b0;
        rdata_by_addr = 1'b0;
        prdata_val    = '0;
        exp_q.delete();
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
    endtask

    // Counts falling edges until dut pulses REQ_DONE; -1 if the bound expires.
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge PCLK);
            if (REQ_DONE !== '0) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESETN = 1'b0;
        REQ_VALID = 2'b11; REQ_WRITE = 2'b11;
        REQ_ADDR = 32'hFFFF_FFFF; REQ_WDATA = '1;
        PREADY = 1'b1; PSLVERR = 1'b0; rdata_by_addr = 1'b0; prdata_val = '1;
        @(negedge PCLK);
        checks++;
        if ({REQ_DONE, RSP_RDATA, RSP_ERR, BUSY, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b rdata=%h err=%b busy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h, required all 0",
                     REQ_DONE, RSP_RDATA, RSP_ERR, BUSY, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        checks++;
        if ({z_done, z_rdata, z_err, z_busy, z_psel, z_penable, z_pwrite, z_paddr, z_pwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_dut0: done=%b rdata=%h busy=%b psel=%b paddr=%h, required all 0",
                     z_done, z_rdata, z_busy, z_psel, z_paddr);
        end
        REQ_VALID = '0;
        PRESETN = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++;
        if (BUSY !== 1'b0 || PSEL !== 1'b0 || REQ_DONE !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b psel=%b done=%b, required 0 0 00", BUSY, PSEL, REQ_DONE);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_read();
        exp_t e;
        apply_reset();
        prdata_val = 32'hDEAD_BEEF;
        REQ_ADDR[15:0] = 16'h0010;
        REQ_VALID = 2'b01;
        exp_q.push_back('{idx: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 16'h0010 || PWRITE !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL setup_c1: psel=%b pen=%b paddr=%h pw=%b busy=%b, required 1 0 0010 0 1", PSEL, PENABLE, PADDR, PWRITE, BUSY);
        end
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || REQ_DONE !== '0) begin
            errors++;
            $display("FAIL access_c2: psel=%b pen=%b done=%b, required 1 1 00", PSEL, PENABLE, REQ_DONE);
        end
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if (REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL single_read_c3: done=%b rdata=%h err=%b psel=%b, required %b %h %b 0",
                     REQ_DONE, RSP_RDATA, RSP_ERR, PSEL, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn read req%0d addr=0010 done=%b rdata=%h err=%b", e.idx, REQ_DONE, RSP_RDATA, RSP_ERR);
        REQ_VALID = '0;
        @(negedge PCLK);
        checks++;
        if (REQ_DONE !== '0 || RSP_RDATA !== '0 || RSP_ERR !== 1'b0 || BUSY !== 1'b0 || PADDR !== 16'h0010) begin
            errors++;
            $display("FAIL after_done_c4: done=%b rdata=%h err=%b busy=%b paddr=%h, required 00 0 0 0 0010",
                     REQ_DONE, RSP_RDATA, RSP_ERR, BUSY, PADDR);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int cyc;
        logic [15:0] a;
        apply_reset();
        rdata_by_addr = 1'b1;
        REQ_ADDR = {16'h0300, 16'h0200};
        REQ_VALID = 2'b11;
        for (int t = 0; t < 4; t++) begin
            a = (t % 2 == 1) ? 16'h0300 : 16'h0200;
            exp_q.push_back('{idx: t % 2, rdata: {a, ~a}, err: 1'b0});
            wait_done(10, cyc);
            checks++;
            if (cyc != ((t == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL rr_period[%0d]: cycles=%0d, required %0d", t, cyc, (t == 0) ? 3 : 4);
            end
            e = exp_q.pop_front();
            checks++;
            if (REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
                errors++;
                $display("FAIL rr_grant[%0d]: done=%b rdata=%h err=%b, required %b %h %b",
                         t, REQ_DONE, RSP_RDATA, RSP_ERR, 2'b01 << e.idx, e.rdata, e.err);
            end
            $display("txn rr[%0d] req%0d done=%b rdata=%h cycles=%0d", t, e.idx, REQ_DONE, RSP_RDATA, cyc);
        end
        REQ_VALID = '0;
    endtask

    task automatic test_wait_slverr();
        exp_t e;
        apply_reset();
        prdata_val = 32'hFFFF_FFFF;
        REQ_ADDR[15:0] = 16'h0100;
        REQ_WDATA[31:0] = 32'h1234_5678;
        REQ_WRITE = 2'b01;
        REQ_VALID = 2'b01;
        PREADY = 1'b0;
        exp_q.push_back('{idx: 0, rdata: 32'h0, err: 1'b1});
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 16'h0100 || PWDATA !== 32'h1234_5678 || PWRITE !== 1'b1) begin
            errors++;
            $display("FAIL write_setup: psel=%b pen=%b paddr=%h pwdata=%h pw=%b", PSEL, PENABLE, PADDR, PWDATA, PWRITE);
        end
        for (int a = 0; a < 6; a++) begin
            @(negedge PCLK);
            checks++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 16'h0100 || PWDATA !== 32'h1234_5678
                || PWRITE !== 1'b1 || REQ_DONE !== '0) begin
                errors++;
                $display("FAIL write_access[%0d]: psel=%b pen=%b paddr=%h pwdata=%h pw=%b done=%b, required 1 1 0100 12345678 1 00",
                         a, PSEL, PENABLE, PADDR, PWDATA, PWRITE, REQ_DONE);
            end
            if (a == 5) begin
                PREADY = 1'b1;
                PSLVERR = 1'b1;
            end
        end
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if (REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
            errors++;
            $display("FAIL write_slverr: done=%b rdata=%h err=%b, required %b %h %b",
                     REQ_DONE, RSP_RDATA, RSP_ERR, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn write req%0d addr=0100 done=%b rdata=%h err=%b", e.idx, REQ_DONE, RSP_RDATA, RSP_ERR);
        REQ_VALID = '0;
        REQ_WRITE = '0;
        PSLVERR = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int n_access;
        int cyc;
        int early;
        logic got;
        apply_reset();
        prdata_val = 32'hCAFE_F00D;
        REQ_ADDR = {16'h0040, 16'h0020};
        REQ_VALID = 2'b10;
        PREADY = 1'b0;
        exp_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b1});
        n_access = 0;
        got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (REQ_DONE !== '0) begin
                got = 1'b1;
                break;
            end
            if (PENABLE === 1'b1) n_access++;
        end
        checks++;
        if (!got || n_access != 8) begin
            errors++;
            $display("FAIL timeout_len: done_seen=%b access_cycles=%0d, required 1 and 8", got, n_access);
        end
        e = exp_q.pop_front();
        checks++;
        if (REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
            errors++;
            $display("FAIL timeout_rsp: done=%b rdata=%h err=%b, required %b %h %b",
                     REQ_DONE, RSP_RDATA, RSP_ERR, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn timeout req%0d done=%b err=%b access=%0d", e.idx, REQ_DONE, RSP_ERR, n_access);
        REQ_VALID = '0;
        @(negedge PCLK);
        // Follow-up read with two wait states: a stale watchdog would abort it.
        REQ_VALID = 2'b01;
        exp_q.push_back('{idx: 0, rdata: 32'hCAFE_F00D, err: 1'b0});
        early = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (REQ_DONE !== '0) early++;
        end
        PREADY = 1'b1;
        wait_done(10, cyc);
        checks++;
        if (early != 0 || cyc != 1) begin
            errors++;
            $display("FAIL followup_latency: early_dones=%0d cycles_after_ready=%0d, required 0 and 1", early, cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if (REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
            errors++;
            $display("FAIL followup_rsp: done=%b rdata=%h err=%b, required %b %h %b",
                     REQ_DONE, RSP_RDATA, RSP_ERR, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn followup req%0d done=%b rdata=%h err=%b", e.idx, REQ_DONE, RSP_RDATA, RSP_ERR);
        REQ_VALID = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc;
        apply_reset();
        prdata_val = 32'h1111_2222;
        REQ_ADDR = {16'h0600, 16'h0500};
        REQ_VALID = 2'b01;
        exp_q.push_back('{idx: 0, rdata: 32'h1111_2222, err: 1'b0});
        wait_done(10, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 3 || REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata) begin
            errors++;
            $display("FAIL pre_reset_txn: cycles=%0d done=%b rdata=%h, required 3 %b %h", cyc, REQ_DONE, RSP_RDATA, 2'b01 << e.idx, e.rdata);
        end
        REQ_VALID = '0;
        @(negedge PCLK);
        REQ_VALID = 2'b11;
        PREADY = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PADDR !== 16'h0600) begin
            errors++;
            $display("FAIL rr_after_req0: psel=%b paddr=%h, required 1 0600", PSEL, PADDR);
        end
        @(negedge PCLK);
        #2 PRESETN = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || BUSY !== 1'b0 || REQ_DONE !== '0) begin
            errors++;
            $display("FAIL async_reset: psel=%b pen=%b busy=%b done=%b, required 0 0 0 00", PSEL, PENABLE, BUSY, REQ_DONE);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        checks++;
        if (REQ_DONE !== '0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL in_reset: done=%b busy=%b, required 00 0", REQ_DONE, BUSY);
        end
        PRESETN = 1'b1;
        exp_q.push_back('{idx: 0, rdata: 32'h1111_2222, err: 1'b0});
        wait_done(10, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 3 || REQ_DONE !== (2'b01 << e.idx) || RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
            errors++;
            $display("FAIL post_reset_grant: cycles=%0d done=%b rdata=%h err=%b, required 3 %b %h %b",
                     cyc, REQ_DONE, RSP_RDATA, RSP_ERR, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn post-reset req%0d done=%b rdata=%h cycles=%0d", e.idx, REQ_DONE, RSP_RDATA, cyc);
        REQ_VALID = '0;
    endtask

    task automatic test_no_timeout();
        exp_t e;
        int early;
        int not_access;
        apply_reset();
        prdata_val = 32'h0BAD_C0DE;
        REQ_ADDR[15:0] = 16'h0030;
        REQ_VALID = 2'b01;
        PREADY = 1'b0;
        exp_q.push_back('{idx: 0, rdata: 32'h0BAD_C0DE, err: 1'b0});
        early = 0;
        not_access = 0;
        for (int i = 1; i <= 1002; i++) begin
            @(negedge PCLK);
            if (z_done !== '0) early++;
            if (i >= 2 && (z_psel !== 1'b1 || z_penable !== 1'b1)) not_access++;
        end
        checks++;
        if (early != 0 || not_access != 0) begin
            errors++;
            $display("FAIL no_abort: dones=%0d non_access_cycles=%0d, required 0 and 0", early, not_access);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if (z_done !== (2'b01 << e.idx) || z_rdata !== e.rdata || z_err !== e.err) begin
            errors++;
            $display("FAIL long_wait_rsp: done=%b rdata=%h err=%b, required %b %h %b",
                     z_done, z_rdata, z_err, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("txn long-wait req%0d done=%b rdata=%h err=%b", e.idx, z_done, z_rdata, z_err);
        REQ_VALID = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_wait_slverr();
        test_timeout();
        test_reset_mid();
        test_no_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 200000ns");
        $fatal(1, "global timeout");
    end

endmodule
